// File: rtl/alu_rr_arbiter_pkg.sv
// Shared ALU control codes, response-slot state encoding and the legal-opcode check.
package alu_pkg;
  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t CTRL_AND = 4'b0000;
  localparam alu_ctrl_t CTRL_OR  = 4'b0001;
  localparam alu_ctrl_t CTRL_ADD = 4'b0010;
  localparam alu_ctrl_t CTRL_SUB = 4'b0110;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic is_legal_ctrl(alu_ctrl_t c);
    return (c == CTRL_AND) || (c == CTRL_OR) || (c == CTRL_ADD) || (c == CTRL_SUB);
  endfunction
endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request, ALU-side and response signals of the shared-ALU arbiter.
interface alu_rr_arbiter_if
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*XLEN-1:0] req_a;
  logic [NUM_REQ*XLEN-1:0] req_b;
  logic [NUM_REQ*4-1:0]    req_ctrl;
  logic [XLEN-1:0]         alu_a;
  logic [XLEN-1:0]         alu_b;
  alu_ctrl_t               alu_ctrl;
  logic [XLEN-1:0]         alu_result;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [XLEN-1:0]         rsp_result;
  logic                    rsp_zero;
  logic                    rsp_err;

  // Slave is the arbiter; master is the requesters, the ALU and the response sink.
  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, req_ctrl, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_rr_arbiter_rr.sv
// Round-robin picker: first set req bit after ptr (wrapping), one-hot gnt plus index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 enable,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (enable) begin
      // Scan ptr+1 .. ptr+N so the last winner has lowest priority.
      for (int k = 1; k <= N; k++) begin
        idx = IW'((int'(ptr) + k) % N);
        if (!found && req[idx]) begin
          found        = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = idx;
        end
      end
    end
  end
endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters; accepted op's result is
// registered into a single response slot (1-cycle latency, no grant while the slot is stalled).
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  alu_rr_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  slot_state_t        state;
  slot_state_t        state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               can_issue;
  logic               accept;

  assign can_issue = !bus.rsp_valid || bus.rsp_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .enable  (can_issue && !reset),
    .gnt     (grant),
    .gnt_idx (grant_idx)
  );

  // A grant is only ever given to a valid requester, so any grant is an accept.
  assign accept        = |grant;
  assign bus.req_ready = grant;

  always_comb begin
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_ctrl = CTRL_AND;
    if (accept) begin
      bus.alu_a    = bus.req_a[int'(grant_idx)*XLEN +: XLEN];
      bus.alu_b    = bus.req_b[int'(grant_idx)*XLEN +: XLEN];
      bus.alu_ctrl = bus.req_ctrl[int'(grant_idx)*4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SLOT_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (accept) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (!accept && bus.rsp_ready) state_nxt = SLOT_EMPTY;
      default:    state_nxt = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    bus.rsp_valid = (state == SLOT_FULL);
  end

  // Payload and priority pointer only move on accept; stalls and idle cycles hold them.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_id     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_err    <= 1'b0;
      rr_ptr         <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      bus.rsp_id     <= grant_idx;
      bus.rsp_result <= bus.alu_result;
      bus.rsp_zero   <= (bus.alu_result == '0);
      bus.rsp_err    <= !is_legal_ctrl(bus.alu_ctrl);
      rr_ptr         <= grant_idx;
    end
  end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed and randomized checks of alu_rr_arbiter against a transaction-level model.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int N = 4;
  localparam int X = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_rr_arbiter_if #(.NUM_REQ(N), .XLEN(X)) bus ();

  alu_rr_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [X-1:0] alu_ref(logic [X-1:0] a, logic [X-1:0] b, logic [3:0] c);
    case (c)
      CTRL_AND: return a & b;
      CTRL_OR:  return a | b;
      CTRL_ADD: return a + b;
      CTRL_SUB: return a - b;
      default:  return a;
    endcase
  endfunction

  // Behavioural ALU sitting on the alu_* ports.
  always_comb bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_ctrl);

  // Reference model state: one response slot and the last-winner index.
  logic         m_valid;
  int           m_id;
  logic [X-1:0] m_res;
  logic         m_zero;
  logic         m_err;
  int           m_ptr;
  int           last_g;

  function automatic int exp_gnt();
    if (reset) return -1;
    if (m_valid && !bus.rsp_ready) return -1;
    for (int k = 1; k <= N; k++) begin
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    int           g;
    logic         rr;
    logic [X-1:0] a, b;
    logic [3:0]   c;
    g  = exp_gnt();
    rr = bus.rsp_ready;
    a  = (g >= 0) ? bus.req_a[g*X +: X] : '0;
    b  = (g >= 0) ? bus.req_b[g*X +: X] : '0;
    c  = (g >= 0) ? bus.req_ctrl[g*4 +: 4] : 4'h0;
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_err = 0; m_ptr = N - 1;
    end else if (g >= 0) begin
      m_valid = 1;
      m_id    = g;
      m_res   = alu_ref(a, b, c);
      m_zero  = (m_res == '0);
      m_err   = !((c == CTRL_AND) || (c == CTRL_OR) || (c == CTRL_ADD) || (c == CTRL_SUB));
      m_ptr   = g;
    end else if (rr) begin
      m_valid = 0;
    end
    last_g = g;
    #1;
  endtask

  task automatic set_req(int i, logic [3:0] c, logic [X-1:0] a, logic [X-1:0] b);
    bus.req_valid[i]       = 1'b1;
    bus.req_ctrl[i*4 +: 4] = c;
    bus.req_a[i*X +: X]    = a;
    bus.req_b[i*X +: X]    = b;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_req(i, CTRL_ADD, 1, 1);
    bus.rsp_ready = 1'b1;
    repeat (2) begin
      tick();
      n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      n_chk++; if ({bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== '0) begin
        n_fail++; $display("FAIL reset_rsp_fields id %0d result %h zero %b err %b want all 0",
                           bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err);
      end
    end
    @(negedge clk); reset = 1'b0; #1;
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_grant got %b want 0001", bus.req_ready); end
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_result !== 32'd2) begin
      n_fail++; $display("FAIL first_rsp valid %b id %0d result %0d want 1/0/2", bus.rsp_valid, bus.rsp_id, bus.rsp_result);
    end
    @(negedge clk); bus.req_valid = '0;
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_single_op();
    @(negedge clk); set_req(1, CTRL_ADD, 5, 7); #1;
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready got %b want 0010", bus.req_ready); end
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 32'd12 ||
                 bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp valid %b id %0d result %0d zero %b err %b want 1/1/12/0/0",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err);
    end
    @(negedge clk); bus.req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int ids [5] = '{0, 1, 2, 3, 0};
    @(negedge clk); reset = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, CTRL_SUB, 9, 9);
      end
      #1;
      n_chk++; if (bus.req_ready !== onehot(ids[k])) begin
        n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", k, bus.req_ready, onehot(ids[k]));
      end
      tick();
      n_chk++; if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != ids[k] || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1) begin
        n_fail++; $display("FAIL rr_rsp[%0d] valid %b id %0d result %0d zero %b want 1/%0d/0/1",
                           k, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero, ids[k]);
      end
    end
    @(negedge clk); bus.req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    @(negedge clk); set_req(1, CTRL_ADD, 1, 2);
    tick();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(1, CTRL_OR, 32'hF0, 32'h0F);
    set_req(2, CTRL_ADD, 10, 20);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0000", k, bus.req_ready); end
      tick();
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 32'd3) begin
        n_fail++; $display("FAIL bp_hold[%0d] valid %b id %0d result %0d want 1/1/3", k, bus.rsp_valid, bus.rsp_id, bus.rsp_result);
      end
    end
    @(negedge clk); bus.rsp_ready = 1'b1; #1;
    n_chk++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release got %b want 0100", bus.req_ready); end
    tick();
    n_chk++; if (bus.rsp_id !== 2'd2 || bus.rsp_result !== 32'd30) begin
      n_fail++; $display("FAIL bp_next id %0d result %0d want 2/30", bus.rsp_id, bus.rsp_result);
    end
    @(negedge clk); bus.req_valid[2] = 1'b0; #1;
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_wrap got %b want 0010", bus.req_ready); end
    tick();
    n_chk++; if (bus.rsp_id !== 2'd1 || bus.rsp_result !== 32'hFF) begin
      n_fail++; $display("FAIL bp_or id %0d result %h want 1/ff", bus.rsp_id, bus.rsp_result);
    end
    @(negedge clk); bus.req_valid = '0;
    tick();
  endtask

  task automatic test_illegal_ctrl();
    @(negedge clk); set_req(2, 4'b1111, 32'hDEAD_BEEF, 32'h1234); #1;
    n_chk++; if (bus.alu_ctrl !== 4'b1111 || bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL ill_issue ctrl %b ready %b want 1111/0100", bus.alu_ctrl, bus.req_ready);
    end
    tick();
    n_chk++; if (bus.rsp_id !== 2'd2 || bus.rsp_result !== 32'hDEAD_BEEF || bus.rsp_err !== 1'b1 || bus.rsp_zero !== 1'b0) begin
      n_fail++; $display("FAIL ill_rsp id %0d result %h err %b zero %b want 2/deadbeef/1/0",
                         bus.rsp_id, bus.rsp_result, bus.rsp_err, bus.rsp_zero);
    end
    @(negedge clk); bus.req_valid = '0;
    tick();
  endtask

  task automatic test_midop_reset();
    @(negedge clk); set_req(3, CTRL_AND, 32'hF0, 32'hFF);
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_result !== 32'hF0) begin
      n_fail++; $display("FAIL mid_accept valid %b id %0d result %h want 1/3/f0", bus.rsp_valid, bus.rsp_id, bus.rsp_result);
    end
    @(negedge clk); bus.req_valid = '0; bus.rsp_ready = 1'b0; reset = 1'b1;
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'd0) begin
      n_fail++; $display("FAIL mid_drop valid %b result %h want 0/0", bus.rsp_valid, bus.rsp_result);
    end
    @(negedge clk); reset = 1'b0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, CTRL_ADD, 0, 0);
    #1;
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr got %b want 0001", bus.req_ready); end
    tick();
    n_chk++; if (bus.rsp_id !== 2'd0 || bus.rsp_zero !== 1'b1) begin
      n_fail++; $display("FAIL mid_after id %0d zero %b want 0/1", bus.rsp_id, bus.rsp_zero);
    end
    @(negedge clk); bus.req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int         g;
    int         waits [N];
    logic [3:0] c;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (last_g >= 0) bus.req_valid[last_g] = 1'b0;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 5))
            0: c = CTRL_AND;
            1: c = CTRL_OR;
            2: c = CTRL_ADD;
            3: c = CTRL_SUB;
            default: c = 4'($urandom);
          endcase
          set_req(i, c, $urandom_range(0, 1) ? $urandom : X'($urandom_range(0, 3)), X'($urandom_range(0, 3)));
          waits[i] = 0;
        end
      end
      #1;
      g = exp_gnt();
      n_chk++; if (bus.req_ready !== onehot(g)) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, bus.req_ready, onehot(g));
      end
      n_chk++;
      if (g >= 0) begin
        if (bus.alu_a !== bus.req_a[g*X +: X] || bus.alu_b !== bus.req_b[g*X +: X] || bus.alu_ctrl !== bus.req_ctrl[g*4 +: 4]) begin
          n_fail++; $display("FAIL rnd_mux cyc %0d a %h b %h ctrl %b for req %0d", cyc, bus.alu_a, bus.alu_b, bus.alu_ctrl, g);
        end
      end else if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_ctrl !== CTRL_AND) begin
        n_fail++; $display("FAIL rnd_idle_mux cyc %0d a %h b %h ctrl %b want 0/0/0000", cyc, bus.alu_a, bus.alu_b, bus.alu_ctrl);
      end
      if (g >= 0) begin
        n_chk++; if (waits[g] >= N) begin n_fail++; $display("FAIL rnd_fair req %0d waited %0d accepts want < %0d", g, waits[g], N); end
        for (int i = 0; i < N; i++) if (i != g && bus.req_valid[i]) waits[i]++;
      end
      tick();
      n_chk++; if (bus.rsp_valid !== m_valid) begin
        n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, bus.rsp_valid, m_valid);
      end
      if (m_valid) begin
        n_chk++; if (int'(bus.rsp_id) != m_id || bus.rsp_result !== m_res || bus.rsp_zero !== m_zero || bus.rsp_err !== m_err) begin
          n_fail++; $display("FAIL rnd_rsp cyc %0d id %0d res %h zero %b err %b want %0d/%h/%b/%b",
                             cyc, bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err, m_id, m_res, m_zero, m_err);
        end
      end
    end
    @(negedge clk); bus.req_valid = '0; bus.rsp_ready = 1'b1;
    tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_ctrl  = '0;
    bus.rsp_ready = 1'b1;
    m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_err = 0; m_ptr = N - 1; last_g = -1;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_illegal_ctrl();
    test_midop_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
    $fatal(1);
  end
endmodule
